// File: rtl/array_nibble_serializer.sv
// rtl/array_nibble_serializer.sv - packed array word to element stream serializer
//
// Purpose: latches one packed N_ELEM x ELEM_W array word per input handshake
// and emits its elements one per output handshake, element 0 first, tagged
// with the element index and a last flag.
//
// Ports:
//   clock_reset [1:0]  bit 0 = clock, bit 1 = asynchronous active-high reset
//   in_data            packed array word (element k at bits [k*ELEM_W +: ELEM_W])
//   in_valid/in_ready  input handshake
//   out_data           current element
//   out_index          index of out_data within its word
//   out_last           out_data is element N_ELEM-1
//   out_valid/out_ready output handshake
//   words_done [15:0]  completed-word counter (only with ARRAY_SER_WORD_COUNT_EN)
//
// Optional feature macro: ARRAY_SER_WORD_COUNT_EN

module array_nibble_serializer #(
  parameter int ELEM_W = 4,
  parameter int N_ELEM = 4,
  parameter int IDX_W  = 2
) (
  input  logic [1:0]               clock_reset,
  input  logic [ELEM_W*N_ELEM-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ELEM_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef ARRAY_SER_WORD_COUNT_EN
  ,
  output logic [15:0]              words_done
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  logic clk;
  logic rst;
  assign clk = clock_reset[0];
  assign rst = clock_reset[1];

  state_t                     state_q;
  logic [ELEM_W*N_ELEM-1:0]   word_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IDX_W-1:0]           idx_d;
  logic [ELEM_W-1:0]          data_q;
  logic                       last_q;
  logic                       valid_q;
  logic                       accept;
  logic                       xfer;

  function automatic logic [ELEM_W-1:0] elem_at(input logic [ELEM_W*N_ELEM-1:0] w,
                                                input logic [IDX_W-1:0] k);
    return w[k*ELEM_W +: ELEM_W];
  endfunction

  // A new word may enter when nothing is held, or when the held word's last
  // element leaves on this very edge (keeps back-to-back words gap-free).
  assign in_ready = !rst && ((state_q == IDLE) || (valid_q && out_ready && last_q));
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;
  assign idx_d    = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SEND;
            word_q  <= in_data;
            idx_q   <= '0;
            data_q  <= elem_at(in_data, '0);
            last_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last_q) begin
              idx_q  <= idx_d;
              data_q <= elem_at(word_q, idx_d);
              last_q <= (idx_d == LAST_IDX);
            end else if (accept) begin
              word_q <= in_data;
              idx_q  <= '0;
              data_q <= elem_at(in_data, '0);
              last_q <= 1'b0;
            end else begin
              // Return outputs to their idle values so out_last never
              // lingers without out_valid.
              state_q <= IDLE;
              idx_q   <= '0;
              data_q  <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

`ifdef ARRAY_SER_WORD_COUNT_EN
  logic [15:0] count_q;

  // Counts only words whose last element actually transferred; 16-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (xfer && last_q) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign words_done = count_q;
`endif

endmodule

// File: tb/tb_array_nibble_serializer.sv
// tb/tb_array_nibble_serializer.sv - self-checking bench for array_nibble_serializer

module tb_array_nibble_serializer;

  localparam int ELEM_W = 4;
  localparam int N_ELEM = 4;
  localparam int IDX_W  = 2;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef ARRAY_SER_WORD_COUNT_EN
  logic [15:0] words_done;
`endif

  int total;
  int bad;

  array_nibble_serializer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .IDX_W(IDX_W)) dut (
    .clock_reset ({rst, clk}),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef ARRAY_SER_WORD_COUNT_EN
    ,
    .words_done  (words_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_index !== 2'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", out_index); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    step();
  endtask

  task automatic test_single();
    in_data = 16'h4321; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = 16'hFFFF;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_data !== 4'(k + 1)) begin bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, out_data, k + 1); end
      total++; if (out_index !== 2'(k)) begin bad++; $display("FAIL single_index k=%0d got=%0d exp=%0d", k, out_index, k); end
      total++; if (out_last !== (k == 3)) begin bad++; $display("FAIL single_last k=%0d got=%b exp=%b", k, out_last, k == 3); end
      step(); #1;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [8];
    exp_d = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
    in_data = 16'h5321; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_data = 16'h0000;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin in_valid = 1'b0; #1; end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, out_valid); end
      total++; if (out_data !== exp_d[k]) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, out_data, exp_d[k]); end
      total++; if (in_ready !== (k == 3 || k == 7)) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=%b", k, in_ready, k == 3 || k == 7); end
      step(); #1;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_data = 16'h4321; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    // element 2 now shown; stall with a competing word offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (out_data !== 4'h2 || out_index !== 2'd1 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold c=%0d got=%h/%0d/%b exp=2/1/1", c, out_data, out_index, out_valid);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
      step(); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step(); #1;
    total++; if (out_data !== 4'h3) begin bad++; $display("FAIL bp_after3 got=%h exp=3", out_data); end
    step(); #1;
    total++; if (out_data !== 4'h4 || out_last !== 1'b1) begin bad++; $display("FAIL bp_after4 got=%h last=%b exp=4/1", out_data, out_last); end
    step(); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    in_data = 16'h4321; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 4'h0 || out_index !== 2'd0 || out_last !== 1'b0) begin
      bad++; $display("FAIL rstmid_out got=%b/%h/%0d/%b exp=0/0/0/0", out_valid, out_data, out_index, out_last);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
    step();
    rst = 1'b0;
    in_data = 16'h8765; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_data !== 4'(k + 5) || out_valid !== 1'b1) begin
        bad++; $display("FAIL rstmid_data k=%0d got=%h exp=%h", k, out_data, k + 5);
      end
      step(); #1;
    end
`ifdef ARRAY_SER_WORD_COUNT_EN
    total++; if (words_done !== 16'd1) begin bad++; $display("FAIL rstmid_words_done got=%0d exp=1", words_done); end
`endif
  endtask

  // Reference: a queue of pending elements; a word pushes all its elements.
  task automatic test_random();
    int q[$];
    int words;
    logic exp_rdy;
    logic acc;
    logic xf;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    words = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      #1;
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        total++; if (out_data !== 4'(q[0] % 16) || out_index !== 2'(q[0] / 16) || out_last !== (q[0] / 16 == N_ELEM - 1)) begin
          bad++; $display("FAIL rnd_elem c=%0d got=%h/%0d/%b exp=%h/%0d", c, out_data, out_index, out_last, q[0] % 16, q[0] / 16);
        end
      end
      exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      acc = in_valid && exp_rdy;
      xf  = out_ready && (q.size() > 0);
      if (xf) begin
        if (q.size() == 1) words++;
        void'(q.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < N_ELEM; k++) q.push_back(k * 16 + ((int'(in_data) >> (4 * k)) & 15));
      end
      step();
    end
`ifdef ARRAY_SER_WORD_COUNT_EN
    #1;
    total++; if (words_done !== 16'(words)) begin bad++; $display("FAIL rnd_words_done got=%0d exp=%0d", words_done, words); end
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
